top_n_peak_stream: RTL

- Parametrised successor to the single-maximum tracker in the harmonic product spectrum path.
- Tracks the NUM_PEAKS largest unsigned magnitudes, with their bin indices, over one framed FFT/HPS stream.
- At frame end, hands the sorted list to a drain bank, which streams it out rank by rank on a valid/ready interface.
- Feeds the pitch estimator, which then chooses among candidate fundamentals instead of only the global maximum.

---
 rtl/top_n_peak_stream_if.sv | 37 +++
 rtl/top_n_peak_stream.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/top_n_peak_stream_if.sv
// Stream interface for top_n_peak_stream.
// Carries the framed magnitude input stream (data_valid/in_ready handshake)
// and the ranked peak output stream (peak_valid/peak_ready handshake),
// plus the sticky overflow flag.
//   slave  : design view (consumes samples, produces peaks)
//   master : environment view (produces samples, consumes peaks)
interface top_n_peak_stream_if #(
    parameter int unsigned MAG_WIDTH  = 96,
    parameter int unsigned K_WIDTH    = 11,
    parameter int unsigned RANK_WIDTH = 2
);
    logic                  data_valid;
    logic                  in_ready;
    logic [MAG_WIDTH-1:0]  data_in;
    logic [K_WIDTH-1:0]    k_in;
    logic                  data_last;
    logic                  peak_valid;
    logic                  peak_ready;
    logic [RANK_WIDTH-1:0] peak_rank;
    logic [K_WIDTH-1:0]    peak_k;
    logic [MAG_WIDTH-1:0]  peak_mag;
    logic                  peak_present;
    logic                  peak_last;
    logic                  overflow;

    modport slave (
        input  data_valid, data_in, k_in, data_last, peak_ready,
        output in_ready, peak_valid, peak_rank, peak_k, peak_mag,
               peak_present, peak_last, overflow
    );

    modport master (
        output data_valid, data_in, k_in, data_last, peak_ready,
        input  in_ready, peak_valid, peak_rank, peak_k, peak_mag,
               peak_present, peak_last, overflow
    );
endinterface

// File: rtl/top_n_peak_stream.sv
// top_n_peak_stream: tracks the NUM_PEAKS largest unsigned magnitudes (with
// bin indices) over one framed stream and, at frame end, hands the sorted
// list to a drain bank that streams it out rank by rank.
// Ports:
//   clock   : system clock
//   reset_n : synchronous active-low reset
//   bus     : top_n_peak_stream_if.slave (sample input stream, peak output
//             stream, sticky overflow)
// Optional build macro: DC_REJECT_EN -- samples with k_in < DC_BINS are
// accepted but never inserted into the list.
module top_n_peak_stream #(
    parameter int unsigned MAG_WIDTH  = 96,
    parameter int unsigned K_WIDTH    = 11,
    parameter int unsigned NUM_PEAKS  = 4,
    parameter int unsigned RANK_WIDTH = 2,
    parameter int unsigned DC_BINS    = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    top_n_peak_stream_if.slave  bus
);

    // Elaboration-time parameter sanity check
    if (NUM_PEAKS < 1 || NUM_PEAKS > 16 || (2 ** RANK_WIDTH) < NUM_PEAKS
        || DC_BINS > (2 ** K_WIDTH)) begin : g_bad_params
        $error("top_n_peak_stream: illegal parameter combination");
    end

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    typedef struct packed {
        logic                 present;
        logic [MAG_WIDTH-1:0] mag;
        logic [K_WIDTH-1:0]   k;
    } entry_t;

    state_e                state_q;
    logic                  in_ready_q;
    logic                  overflow_q;
    logic                  valid_q;
    logic [RANK_WIDTH-1:0] rank_q;
    logic                  last_q;
    entry_t                acc_q [NUM_PEAKS];
    entry_t                drn_q [NUM_PEAKS];
    entry_t                ins_d [NUM_PEAKS];

    logic   accept_c;
    logic   elig_c;
    int     pos_c;
    entry_t new_c;

    assign accept_c = bus.data_valid & in_ready_q;

`ifdef DC_REJECT_EN
    assign elig_c = (bus.k_in >= K_WIDTH'(DC_BINS));
`else
    assign elig_c = 1'b1;
`endif

    // Sorted insertion: new entry lands below every present entry with mag >= data_in
    always_comb begin
        ins_d = acc_q;
        pos_c = 0;
        new_c = '{present: 1'b1, mag: bus.data_in, k: bus.k_in};
        for (int i = 0; i < int'(NUM_PEAKS); i++) begin
            if (acc_q[i].present && (acc_q[i].mag >= bus.data_in)) begin
                pos_c = pos_c + 1;
            end
        end
        if (elig_c) begin
            if (pos_c == 0) begin
                ins_d[0] = new_c;
            end
            for (int i = 1; i < int'(NUM_PEAKS); i++) begin
                if (i == pos_c) begin
                    ins_d[i] = new_c;
                end else if (i > pos_c) begin
                    ins_d[i] = acc_q[i-1];
                end
            end
        end
    end

    // Control FSM, accumulation list and drain bank
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_ACCUM;
            in_ready_q <= 1'b1;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            rank_q     <= '0;
            last_q     <= 1'b0;
            for (int i = 0; i < int'(NUM_PEAKS); i++) begin
                acc_q[i] <= '0;
                drn_q[i] <= '0;
            end
        end else begin
            // Drain: slot 0 is the visible beat, the bank shifts up on each handshake
            if (valid_q && bus.peak_ready) begin
                for (int i = 0; i < int'(NUM_PEAKS) - 1; i++) begin
                    drn_q[i] <= drn_q[i+1];
                end
                drn_q[NUM_PEAKS-1] <= '0;
                if (last_q) begin
                    valid_q <= 1'b0;
                    rank_q  <= '0;
                    last_q  <= 1'b0;
                end else begin
                    rank_q <= rank_q + RANK_WIDTH'(1);
                    last_q <= ((rank_q + RANK_WIDTH'(1)) == RANK_WIDTH'(NUM_PEAKS - 1));
                end
            end

            case (state_q)
                ST_ACCUM: begin
                    if (accept_c) begin
                        if (!bus.data_last) begin
                            acc_q <= ins_d;
                        end else if (!valid_q) begin
                            drn_q   <= ins_d;
                            valid_q <= 1'b1;
                            rank_q  <= '0;
                            last_q  <= (NUM_PEAKS == 1);
                            for (int i = 0; i < int'(NUM_PEAKS); i++) begin
                                acc_q[i] <= '0;
                            end
                        end else begin
                            // Bank still busy: park the finished list
                            acc_q      <= ins_d;
                            state_q    <= ST_HOLD;
                            in_ready_q <= 1'b0;
                            overflow_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!valid_q) begin
                        drn_q      <= acc_q;
                        valid_q    <= 1'b1;
                        rank_q     <= '0;
                        last_q     <= (NUM_PEAKS == 1);
                        state_q    <= ST_ACCUM;
                        in_ready_q <= 1'b1;
                        for (int i = 0; i < int'(NUM_PEAKS); i++) begin
                            acc_q[i] <= '0;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_ACCUM;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.overflow     = overflow_q;
    assign bus.peak_valid   = valid_q;
    assign bus.peak_rank    = rank_q;
    assign bus.peak_last    = last_q;
    assign bus.peak_present = drn_q[0].present;
    assign bus.peak_mag     = drn_q[0].mag;
    assign bus.peak_k       = drn_q[0].k;

endmodule
